// File: rtl/page_table_walker.sv
// page_table_walker: two-level hardware page-table walker.
// A TLB miss is walked through a 10b/10b/12b table over a single-outstanding
// memory read port. The walk ends in a one-cycle TLB fill pulse or a one-cycle
// fault pulse with a cause code.
// Optional feature macro: PTW_SUPERPAGE_EN. When it is defined, a valid L1 PTE
// with bit [1] set is a 4 MB leaf and the L2 read is skipped.
module page_table_walker #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ptbr,
    input  logic        miss_valid,
    input  logic [31:0] miss_vaddr,
    output logic        miss_ready,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        mmu_update_valid,
    output logic [31:0] mmu_vaddr,
    output logic [31:0] mmu_paddr,
    output logic        fault_valid,
    output logic [1:0]  fault_cause
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L2_REQ  = 3'd3,
        L2_WAIT = 3'd4,
        DONE    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_L1_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_L2_INVALID = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    // Counter value seen during the last permitted silent WAIT cycle; a missing
    // response in that cycle means TIMEOUT_CYCLES cycles have passed unanswered.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [31:0]       va_q, va_d;
    logic [19:0]       root_q, root_d;
    logic [19:0]       pte1_q, pte1_d;
    logic [31:0]       paddr_q, paddr_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // PTE fields that the walk never looks at (flags other than valid/leaf,
    // page offset bits of the root pointer).
    logic unused_bits;
    assign unused_bits = ^{ptbr[11:0], mem_resp_data[11:1]};

    // State, walk latches and timeout counter; everything returns to its idle value on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            va_q    <= '0;
            root_q  <= '0;
            pte1_q  <= '0;
            paddr_q <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            root_q  <= root_d;
            pte1_q  <= pte1_d;
            paddr_q <= paddr_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore outputs; outputs are zero outside the state that owns them.
    always_comb begin
        state_d          = state_q;
        va_d             = va_q;
        root_d           = root_q;
        pte1_d           = pte1_q;
        paddr_d          = paddr_q;
        cause_d          = cause_q;
        cnt_d            = cnt_q;
        miss_ready       = 1'b0;
        mem_req_valid    = 1'b0;
        mem_req_addr     = 32'h0;
        mmu_update_valid = 1'b0;
        mmu_vaddr        = 32'h0;
        mmu_paddr        = 32'h0;
        fault_valid      = 1'b0;
        fault_cause      = 2'b00;

        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    va_d    = miss_vaddr;
                    root_d  = ptbr[31:12];
                    state_d = L1_REQ;
                end
            end

            L1_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {root_q, va_q[31:22], 2'b00};
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = L1_WAIT;
                end
            end

            L1_WAIT: begin
                // A response always wins over an expiring counter.
                if (mem_resp_valid) begin
                    pte1_d = mem_resp_data[31:12];
                    if (!mem_resp_data[0]) begin
                        cause_d = CAUSE_L1_INVALID;
                        state_d = FAULT;
                    end else begin
`ifdef PTW_SUPERPAGE_EN
                        if (mem_resp_data[1]) begin
                            paddr_d = {mem_resp_data[31:22], va_q[21:0]};
                            state_d = DONE;
                        end else begin
                            state_d = L2_REQ;
                        end
`else
                        state_d = L2_REQ;
`endif
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            L2_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {pte1_q, va_q[21:12], 2'b00};
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = L2_WAIT;
                end
            end

            L2_WAIT: begin
                if (mem_resp_valid) begin
                    if (!mem_resp_data[0]) begin
                        cause_d = CAUSE_L2_INVALID;
                        state_d = FAULT;
                    end else begin
                        paddr_d = {mem_resp_data[31:12], va_q[11:0]};
                        state_d = DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                mmu_update_valid = 1'b1;
                mmu_vaddr        = va_q;
                mmu_paddr        = paddr_q;
                state_d          = IDLE;
            end

            FAULT: begin
                fault_valid = 1'b1;
                fault_cause = cause_q;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker (honours PTW_SUPERPAGE_EN when defined).
module tb_page_table_walker;

    localparam int TO = 255;

    logic        clk;
    logic        reset_n;
    logic [31:0] ptbr;
    logic        miss_valid;
    logic [31:0] miss_vaddr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mmu_update_valid;
    logic [31:0] mmu_vaddr;
    logic [31:0] mmu_paddr;
    logic        fault_valid;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_fail   = 0;

    page_table_walker #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ptbr             (ptbr),
        .miss_valid       (miss_valid),
        .miss_vaddr       (miss_vaddr),
        .miss_ready       (miss_ready),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .mmu_update_valid (mmu_update_valid),
        .mmu_vaddr        (mmu_vaddr),
        .mmu_paddr        (mmu_paddr),
        .fault_valid      (fault_valid),
        .fault_cause      (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nreads;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [1:0]  cause;
        logic [31:0] paddr;
        int          cycle;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of a walk from the table rules. Cycle numbers count
    // from the accept edge: each REQ state lasts 1+stall cycles, each WAIT
    // state lasts lat cycles (or TO cycles when no answer comes), and the
    // terminal DONE/FAULT cycle follows.
    function automatic exp_t model(input logic [31:0] p, input logic [31:0] va,
                                   input logic [31:0] d0, input logic [31:0] d1,
                                   input int s0, input int l0, input int s1, input int l1);
        exp_t e;
        e.a1     = (p & 32'hFFFF_F000) + ((va >> 22) << 2);
        e.a2     = (d0 & 32'hFFFF_F000) + (((va >> 12) & 32'h3FF) << 2);
        e.cause  = 2'd0;
        e.paddr  = 32'h0;
        e.nreads = 1;
        e.cycle  = 1 + s0;
        if (l0 > TO) begin
            e.cause = 2'd3;
            e.cycle += TO + 1;
            return e;
        end
        e.cycle += l0;
        if (d0[0] == 1'b0) begin
            e.cause = 2'd1;
            e.cycle += 1;
            return e;
        end
`ifdef PTW_SUPERPAGE_EN
        if (d0[1] == 1'b1) begin
            e.paddr = (d0 & 32'hFFC0_0000) | (va & 32'h003F_FFFF);
            e.cycle += 1;
            return e;
        end
`endif
        e.nreads = 2;
        e.cycle += 1 + s1;
        if (l1 > TO) begin
            e.cause = 2'd3;
            e.cycle += TO + 1;
            return e;
        end
        e.cycle += l1;
        if (d1[0] == 1'b0) begin
            e.cause = 2'd2;
        end else begin
            e.paddr = (d1 & 32'hFFFF_F000) | (va & 32'h0000_0FFF);
        end
        e.cycle += 1;
        return e;
    endfunction

    // One miss from accept to the cycle after its outcome, playing the memory side.
    task automatic walk(input logic [31:0] p, input logic [31:0] va,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int s0, input int l0, input int s1, input int l1,
                        input bit hold, input bit late, input bit abort);
        exp_t        e;
        logic [31:0] d[2];
        int          l[2];
        int          cyc, reads, wait_cnt, stall_left, done, ri;
        bit          waiting, aborted;
        d[0] = d0; d[1] = d1; l[0] = l0; l[1] = l1;
        e = model(p, va, d0, d1, s0, l0, s1, l1);
        chk("idle_ready", miss_ready, 1);
        miss_valid = 1'b1;
        miss_vaddr = va;
        ptbr       = p;
        @(posedge clk); @(negedge clk);
        cyc = 1; reads = 0; wait_cnt = 0; stall_left = s0; done = 0;
        waiting = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 2000 && done == 0; k++) begin
            miss_valid     = hold;
            miss_vaddr     = ~va;
            ptbr           = ~p;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
            if (mmu_update_valid === 1'b1 || fault_valid === 1'b1) begin
                miss_valid = 1'b0;
                done = 1;
                chk("end_cycle", cyc, e.cycle);
                chk("update_flag", mmu_update_valid, e.cause == 2'd0);
                chk("fault_flag", fault_valid, e.cause != 2'd0);
                chk("fault_cause", fault_cause, e.cause);
                chk("mem_reads", reads, e.nreads);
                if (e.cause == 2'd0) begin
                    chk("mmu_vaddr", mmu_vaddr, va);
                    chk("mmu_paddr", mmu_paddr, e.paddr);
                end
            end else begin
                chk("busy_ready", miss_ready, 0);
                if (mem_req_valid === 1'b1) begin
                    if (reads < e.nreads)
                        chk("req_addr", mem_req_addr, (reads == 0) ? e.a1 : e.a2);
                    else
                        chk("req_count", reads + 1, e.nreads);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_req_ready = 1'b1;
                        reads++;
                        waiting  = 1'b1;
                        wait_cnt = 0;
                        stall_left = s1;
                    end
                end else if (waiting) begin
                    if (abort && reads == 2) begin
                        reset_n = 1'b0;
                        #1;
                        chk("rst_ready", miss_ready, 1);
                        chk("rst_req", mem_req_valid, 0);
                        chk("rst_addr", mem_req_addr, 0);
                        chk("rst_update", mmu_update_valid, 0);
                        chk("rst_fault", fault_valid, 0);
                        @(posedge clk); @(negedge clk);
                        reset_n = 1'b1;
                        miss_valid = 1'b0;
                        @(posedge clk); @(negedge clk);
                        chk("post_rst_ready", miss_ready, 1);
                        chk("post_rst_update", mmu_update_valid, 0);
                        aborted = 1'b1;
                        done = 1;
                    end else begin
                        wait_cnt++;
                        ri = (reads > 2) ? 1 : reads - 1;
                        if (wait_cnt == l[ri]) begin
                            mem_resp_valid = 1'b1;
                            mem_resp_data  = d[ri];
                            waiting = 1'b0;
                        end
                    end
                end
            end
            if (done == 0) begin
                @(posedge clk); @(negedge clk);
                cyc++;
            end
        end
        chk("walk_done", done, 1);
        miss_valid = 1'b0;
        if (!aborted) begin
            @(posedge clk); @(negedge clk);
            chk("after_ready", miss_ready, 1);
            chk("after_update", mmu_update_valid, 0);
            chk("after_fault", fault_valid, 0);
            chk("after_req", mem_req_valid, 0);
            if (late) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'h0ABC_D001;
                @(posedge clk); @(negedge clk);
                mem_resp_valid = 1'b0;
                chk("late_ready", miss_ready, 1);
                chk("late_update", mmu_update_valid, 0);
                chk("late_fault", fault_valid, 0);
                chk("late_req", mem_req_valid, 0);
            end
        end
    endtask

    initial begin
        logic [31:0] rp, rva, rd0, rd1;
        reset_n        = 1'b0;
        ptbr           = 32'h0;
        miss_valid     = 1'b0;
        miss_vaddr     = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("reset_ready", miss_ready, 1);
        chk("reset_req", mem_req_valid, 0);
        chk("reset_addr", mem_req_addr, 0);
        chk("reset_update", mmu_update_valid, 0);
        chk("reset_vaddr", mmu_vaddr, 0);
        chk("reset_paddr", mmu_paddr, 0);
        chk("reset_fault", fault_valid, 0);
        chk("reset_cause", fault_cause, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reference walk, minimum latency
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0001, 32'h0ABC_D001, 0, 1, 0, 1, 0, 0, 0);
        // L1 invalid
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0000, 32'h0ABC_D001, 0, 1, 0, 1, 0, 0, 0);
        // L1 request stalled three cycles
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0001, 32'h0ABC_D001, 3, 1, 0, 1, 0, 0, 0);
        // L1 timeout, then a stray response while idle
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0001, 32'h0ABC_D001, 0, TO + 1, 0, 1, 0, 1, 0);
        // Response in the expiry cycle proceeds
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0001, 32'h0ABC_D001, 0, TO, 0, 1, 0, 0, 0);
        // L2 invalid, L2 stall and slow responses
        walk(32'h0003_0000, 32'hFFC0_1234, 32'h0004_5001, 32'h0ABC_D000, 1, 2, 2, 3, 0, 0, 0);
        // L2 timeout
        walk(32'h0003_0000, 32'h1234_5678, 32'h0004_5001, 32'h0ABC_D001, 0, 1, 0, TO + 1, 0, 0, 0);
        // Reset during L2_WAIT, then a clean walk
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0001, 32'h0ABC_D001, 0, 1, 0, 2, 0, 0, 1);
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_0001, 32'h0ABC_D001, 0, 1, 0, 1, 0, 0, 0);
        // Leaf-marked L1 PTE (superpage or two reads depending on build)
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h1C00_0003, 32'h0ABC_D001, 0, 1, 0, 1, 0, 0, 0);
        // Requester holds miss_valid with other inputs while busy
        walk(32'h0005_0000, 32'h8765_4321, 32'h0006_7001, 32'h0DEF_0001, 1, 1, 1, 1, 1, 0, 0);

        // Randomized walks
        for (int i = 0; i < 30; i++) begin
            rp  = $urandom();
            rva = $urandom();
            rd0 = ($urandom() & 32'hFFFF_F000) | {30'h0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0)};
            rd1 = ($urandom() & 32'hFFFF_F000) | {31'h0, ($urandom_range(0, 7) != 0)};
            walk(rp, rva, rd0, rd1, $urandom_range(0, 3), $urandom_range(1, 4),
                 $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 1) == 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
